// File: rtl/jt900h_bus_resp_pkg.sv
// Shared types and helpers for the jt900h RAM-bus responder: FSM states,
// decode regions and the byte-lane merge used by writes.
package jt900h_bus_resp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXT  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_EXT  = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  // Internal RAM wins over the external window when the two overlap
  function automatic region_t decode(input logic [23:0] addr,
                                     input logic [23:0] ram_lo,
                                     input logic [23:0] ram_hi,
                                     input logic [23:0] ext_lo,
                                     input logic [23:0] ext_hi);
    if (addr >= ram_lo && addr <= ram_hi) return REG_RAM;
    if (addr >= ext_lo && addr <= ext_hi) return REG_EXT;
    return REG_NONE;
  endfunction

  function automatic logic [15:0] byte_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0]  we);
    return {we[1] ? new_w[15:8] : old_w[15:8],
            we[0] ? new_w[7:0]  : old_w[7:0]};
  endfunction

endpackage

// File: rtl/jt900h_bus_resp_if.sv
// CPU RAM bus plus external word port, as seen by the responder (slave)
// and by whatever drives the CPU/external side (master).
interface jt900h_bus_resp_if;
  logic        cpu_cen;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_we;
  logic [15:0] ram_dout;
  logic [22:0] ext_addr;
  logic [15:0] ext_din;
  logic [1:0]  ext_we;
  logic        ext_req;
  logic        ext_ack;
  logic [15:0] ext_dout;
  logic        bus_err;

  modport slave (
    input  ram_addr, ram_din, ram_we, ext_ack, ext_dout,
    output cpu_cen, ram_dout, ext_addr, ext_din, ext_we, ext_req, bus_err
  );

  modport master (
    output ram_addr, ram_din, ram_we, ext_ack, ext_dout,
    input  cpu_cen, ram_dout, ext_addr, ext_din, ext_we, ext_req, bus_err
  );
endinterface

// File: rtl/jt900h_bus_resp_ram.sv
// Single-port internal RAM, byte write enables, registered read-first port.
module jt900h_bus_resp_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   din_i,
  output logic [15:0]   dout_o
);

  logic [15:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (en_i) begin
      dout_o <= mem_q[addr_i];
      if (we_i[0]) mem_q[addr_i][7:0]  <= din_i[7:0];
      if (we_i[1]) mem_q[addr_i][15:8] <= din_i[15:8];
    end
  end

endmodule

// File: rtl/jt900h_bus_resp.sv
// RAM-bus responder: decodes CPU accesses to internal RAM, external port or
// unmapped space, stalls the CPU during external handshakes, one-word buffer.
module jt900h_bus_resp
  import jt900h_bus_resp_pkg::*;
#(
  parameter logic [23:0] RAM_BASE   = 24'h004000,
  parameter int          RAM_AW     = 12,
  parameter logic [23:0] EXT_BASE   = 24'h200000,
  parameter logic [23:0] EXT_END    = 24'h3FFFFF,
  parameter int          TIMEOUT    = 255,
  parameter logic [15:0] UNMAP_DATA = 16'hFFFF
) (
  input logic clk,
  input logic rst,
  input logic cen,
  jt900h_bus_resp_if.slave bus
);

  localparam logic [23:0] RAM_LAST = RAM_BASE + 24'((2 ** (RAM_AW + 1)) - 1);
  localparam int          CW       = $clog2(TIMEOUT + 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [1:0]  we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] dout_q, dout_d;
  logic        src_ram_q, src_ram_d;
  logic        err_q, err_d;
  logic        bvalid_q, bvalid_d;
  logic [22:0] btag_q, btag_d;
  logic [15:0] bdata_q, bdata_d;

  logic        cpu_cen, rd, hit, ram_en;
  region_t     region;
  logic [22:0] word;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0] ram_rdata;

  assign cpu_cen = cen & (state_q == IDLE);
  assign region  = decode(bus.ram_addr, RAM_BASE, RAM_LAST, EXT_BASE, EXT_END);
  assign word    = bus.ram_addr[23:1];
  assign rd      = (bus.ram_we == 2'b00);
  assign hit     = bvalid_q && (btag_q == word);
  assign ram_idx = RAM_AW'((bus.ram_addr - RAM_BASE) >> 1);
  assign ram_en  = cpu_cen && !rst && (region == REG_RAM);

  jt900h_bus_resp_ram #(.AW(RAM_AW)) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .addr_i (ram_idx),
    .we_i   (bus.ram_we),
    .din_i  (bus.ram_din),
    .dout_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    src_ram_d = src_ram_q;
    err_d     = err_q;
    bvalid_d  = bvalid_q;
    btag_d    = btag_q;
    bdata_d   = bdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_cen) begin
          case (region)
            REG_RAM: src_ram_d = 1'b1;
            REG_EXT: begin
              if (rd && hit) begin
                dout_d    = bdata_q;
                src_ram_d = 1'b0;
              end else begin
                state_d = EXT;
                req_d   = 1'b1;
                addr_d  = word;
                din_d   = bus.ram_din;
                we_d    = bus.ram_we;
                cnt_d   = CW'(1);
                if (!rd && hit) bdata_d = byte_merge(bdata_q, bus.ram_din, bus.ram_we);
              end
            end
            default: begin
              if (rd) begin
                dout_d    = UNMAP_DATA;
                src_ram_d = 1'b0;
              end
            end
          endcase
        end
      end
      EXT: begin
        cnt_d = cnt_q + CW'(1);
        // cnt_q counts cycles with ext_req high, so ack in the same cycle beats timeout
        if (bus.ext_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (we_q == 2'b00) begin
            dout_d    = bus.ext_dout;
            src_ram_d = 1'b0;
            bvalid_d  = 1'b1;
            btag_d    = addr_q;
            bdata_d   = bus.ext_dout;
          end
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          dout_d    = UNMAP_DATA;
          src_ram_d = 1'b0;
          err_d     = 1'b1;
          bvalid_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      src_ram_q <= 1'b0;
      err_q     <= 1'b0;
      bvalid_q  <= 1'b0;
      btag_q    <= '0;
      bdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      src_ram_q <= src_ram_d;
      err_q     <= err_d;
      bvalid_q  <= bvalid_d;
      btag_q    <= btag_d;
      bdata_q   <= bdata_d;
    end
  end

  assign bus.cpu_cen  = cpu_cen;
  assign bus.ram_dout = src_ram_q ? ram_rdata : dout_q;
  assign bus.ext_addr = addr_q;
  assign bus.ext_din  = din_q;
  assign bus.ext_we   = we_q;
  assign bus.ext_req  = req_q;
  assign bus.bus_err  = err_q;

endmodule

// File: tb/tb_jt900h_bus_resp.sv
// Self-checking bench for jt900h_bus_resp: directed plan items, randomized
// accesses against a behavioural memory/buffer model, cen and reset corners.
module tb_jt900h_bus_resp;

  localparam int          TO   = 8;
  localparam logic [23:0] PARK = 24'h800000;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  always #5 clk = ~clk;

  jt900h_bus_resp_if bus();

  jt900h_bus_resp #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        req;
    int          stall;
    logic [22:0] xaddr;
    logic [1:0]  xwe;
    logic [15:0] xdin;
    logic        chk_dout;
    logic [15:0] dout;
    logic        err;
  } exp_t;

  typedef struct {
    logic        req;
    int          stall;
    logic [22:0] xaddr;
    logic [1:0]  xwe;
    logic [15:0] xdin;
    logic        cen_ok;
    logic [15:0] dout;
    logic        err;
  } obs_t;

  typedef struct {
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0]  we;
    int          dly;
    logic [15:0] val;
  } acc_t;

  // behavioural model: word-indexed RAM image, one buffered word, sticky error
  logic [15:0] mem_m [4096];
  bit          known_m [4096];
  bit          bvalid_m;
  logic [22:0] btag_m;
  logic [15:0] bdata_m;
  bit          err_m;

  task automatic model_reset();
    bvalid_m = 0;
    err_m    = 0;
  endtask

  task automatic model(input acc_t c, output exp_t e);
    logic [22:0] w;
    int idx;
    w = c.a[23:1];
    e.req = 0; e.stall = 0; e.xaddr = '0; e.xwe = '0; e.xdin = '0;
    e.chk_dout = 0; e.dout = '0;
    if (c.a >= 24'h004000 && c.a <= 24'h005FFF) begin
      idx = int'((c.a - 24'h004000) / 2);
      e.chk_dout = known_m[idx];
      e.dout     = mem_m[idx];
      if (c.we[0]) mem_m[idx][7:0]  = c.d[7:0];
      if (c.we[1]) mem_m[idx][15:8] = c.d[15:8];
      if (c.we == 2'b11) known_m[idx] = 1;
    end else if (c.a >= 24'h200000 && c.a <= 24'h3FFFFF) begin
      if (c.we == 2'b00 && bvalid_m && btag_m == w) begin
        e.chk_dout = 1;
        e.dout     = bdata_m;
      end else begin
        e.req = 1; e.xaddr = w; e.xwe = c.we; e.xdin = c.d;
        if (c.we != 2'b00 && bvalid_m && btag_m == w) begin
          if (c.we[0]) bdata_m[7:0]  = c.d[7:0];
          if (c.we[1]) bdata_m[15:8] = c.d[15:8];
        end
        if (c.dly == 0 || c.dly > TO) begin
          e.stall = TO; e.chk_dout = 1; e.dout = 16'hFFFF;
          err_m = 1; bvalid_m = 0;
        end else begin
          e.stall = c.dly;
          if (c.we == 2'b00) begin
            e.chk_dout = 1; e.dout = c.val;
            bvalid_m = 1; btag_m = w; bdata_m = c.val;
          end
        end
      end
    end else if (c.we == 2'b00) begin
      e.chk_dout = 1;
      e.dout     = 16'hFFFF;
    end
    e.err = err_m;
  endtask

  // Present one access at the sampling edge, play the external device, observe
  task automatic drive_access(input acc_t c, output obs_t o);
    @(negedge clk);
    bus.ram_addr = c.a;
    bus.ram_din  = c.d;
    bus.ram_we   = c.we;
    @(posedge clk); #1;
    bus.ram_addr = PARK;
    bus.ram_we   = 2'b00;
    o.req = bus.ext_req; o.xaddr = bus.ext_addr; o.xwe = bus.ext_we; o.xdin = bus.ext_din;
    o.stall = 0; o.cen_ok = 1;
    while (bus.ext_req === 1'b1 && o.stall < 300) begin
      o.stall++;
      if (bus.cpu_cen !== 1'b0) o.cen_ok = 0;
      if (c.dly != 0 && o.stall == c.dly) begin
        bus.ext_ack  = 1'b1;
        bus.ext_dout = c.val;
      end
      @(posedge clk); #1;
      bus.ext_ack  = 1'b0;
      bus.ext_dout = 16'($urandom);
    end
    if (bus.cpu_cen !== cen) o.cen_ok = 0;
    o.dout = bus.ram_dout;
    o.err  = bus.bus_err;
  endtask

  task automatic test_reset();
    cen = 1'b0; rst = 1'b1;
    bus.ram_addr = PARK; bus.ram_din = '0; bus.ram_we = '0;
    bus.ext_ack = 1'b0; bus.ext_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (bus.ram_dout !== 16'h0) begin
      errors++; $display("FAIL reset_dout got=%h exp=0000", bus.ram_dout);
    end
    checks++;
    if (bus.ext_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got=%b exp=0", bus.ext_req);
    end
    checks++;
    if (bus.ext_addr !== 23'h0 || bus.ext_we !== 2'b0 || bus.ext_din !== 16'h0) begin
      errors++;
      $display("FAIL reset_ext got=%h/%b/%h exp=0/0/0", bus.ext_addr, bus.ext_we, bus.ext_din);
    end
    checks++;
    if (bus.bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b exp=0", bus.bus_err);
    end
    checks++;
    if (bus.cpu_cen !== 1'b0) begin
      errors++; $display("FAIL reset_cen0 got=%b exp=0", bus.cpu_cen);
    end
    @(negedge clk); cen = 1'b1; #1;
    checks++;
    if (bus.cpu_cen !== 1'b1) begin
      errors++; $display("FAIL reset_cen1 got=%b exp=1", bus.cpu_cen);
    end
  endtask

  task automatic check_access(input string tag, input int i, input exp_t e, input obs_t o);
    checks++;
    if (o.req !== e.req) begin
      errors++; $display("FAIL %s%0d_req got=%b exp=%b", tag, i, o.req, e.req);
    end
    checks++;
    if (o.stall != e.stall) begin
      errors++; $display("FAIL %s%0d_stall got=%0d exp=%0d", tag, i, o.stall, e.stall);
    end
    checks++;
    if (o.cen_ok !== 1'b1) begin
      errors++; $display("FAIL %s%0d_cpu_cen got=bad exp=low only while req", tag, i);
    end
    if (e.req) begin
      checks++;
      if (o.xaddr !== e.xaddr || o.xwe !== e.xwe || (e.xwe != 0 && o.xdin !== e.xdin)) begin
        errors++;
        $display("FAIL %s%0d_ext got=%h/%b/%h exp=%h/%b/%h", tag, i, o.xaddr, o.xwe, o.xdin,
                 e.xaddr, e.xwe, e.xdin);
      end
    end
    if (e.chk_dout) begin
      checks++;
      if (o.dout !== e.dout) begin
        errors++; $display("FAIL %s%0d_dout got=%h exp=%h", tag, i, o.dout, e.dout);
      end
    end
    checks++;
    if (o.err !== e.err) begin
      errors++; $display("FAIL %s%0d_err got=%b exp=%b", tag, i, o.err, e.err);
    end
  endtask

  task automatic test_directed();
    acc_t tbl [16];
    exp_t e;
    obs_t o;
    tbl = '{
      '{24'h004010, 16'hA55A, 2'b11, 0, 16'h0},
      '{24'h004010, 16'h0000, 2'b00, 0, 16'h0},
      '{24'h004010, 16'h0012, 2'b01, 0, 16'h0},
      '{24'h004010, 16'h0000, 2'b00, 0, 16'h0},
      '{24'h200100, 16'h0000, 2'b00, 3, 16'hBEEF},
      '{24'h200100, 16'h0000, 2'b00, 1, 16'h0000},
      '{24'h200101, 16'h1234, 2'b10, 1, 16'h0000},
      '{24'h200100, 16'h0000, 2'b00, 1, 16'h0000},
      '{24'h200200, 16'h0000, 2'b00, 0, 16'h0000},
      '{24'h200200, 16'h0000, 2'b00, 2, 16'hCAFE},
      '{24'h800000, 16'h0000, 2'b00, 0, 16'h0},
      '{24'h005FFE, 16'h7777, 2'b11, 0, 16'h0},
      '{24'h005FFF, 16'h0000, 2'b00, 0, 16'h0},
      '{24'h006000, 16'h0000, 2'b00, 0, 16'h0},
      '{24'h3FFFFE, 16'h0000, 2'b00, TO, 16'hACE1},
      '{24'h1FFFFE, 16'h0000, 2'b00, 0, 16'h0}
    };
    foreach (tbl[i]) begin
      model(tbl[i], e);
      drive_access(tbl[i], o);
      check_access("dir", i, e, o);
    end
  endtask

  task automatic test_cen_hold();
    acc_t c;
    exp_t e;
    obs_t o;
    logic [15:0] held;
    c = '{24'h004010, 16'h0, 2'b00, 0, 16'h0};
    model(c, e);
    drive_access(c, o);
    held = o.dout;
    checks++;
    if (held !== e.dout) begin
      errors++; $display("FAIL cen_pre_dout got=%h exp=%h", held, e.dout);
    end
    cen = 1'b0;
    @(negedge clk);
    bus.ram_addr = 24'h005FFE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.ram_addr = 24'h200204;
    @(posedge clk); #1;
    checks++;
    if (bus.ram_dout !== held) begin
      errors++; $display("FAIL cen_hold_dout got=%h exp=%h", bus.ram_dout, held);
    end
    checks++;
    if (bus.ext_req !== 1'b0) begin
      errors++; $display("FAIL cen_hold_req got=%b exp=0", bus.ext_req);
    end
    checks++;
    if (bus.cpu_cen !== 1'b0) begin
      errors++; $display("FAIL cen_hold_cpu_cen got=%b exp=0", bus.cpu_cen);
    end
    @(negedge clk);
    bus.ram_addr = PARK;
    cen = 1'b1;
  endtask

  task automatic test_ext_cen_low();
    acc_t c;
    exp_t e;
    obs_t o;
    c = '{24'h200302, 16'h0, 2'b00, 2, 16'h5A5A};
    model(c, e);
    @(negedge clk);
    bus.ram_addr = c.a; bus.ram_we = c.we;
    @(posedge clk); #1;
    bus.ram_addr = PARK;
    cen = 1'b0;
    o.stall = 0;
    while (bus.ext_req === 1'b1 && o.stall < 300) begin
      o.stall++;
      if (o.stall == c.dly) begin bus.ext_ack = 1'b1; bus.ext_dout = c.val; end
      @(posedge clk); #1;
      bus.ext_ack = 1'b0;
    end
    checks++;
    if (o.stall != e.stall) begin
      errors++; $display("FAIL extcen_stall got=%0d exp=%0d", o.stall, e.stall);
    end
    checks++;
    if (bus.ram_dout !== e.dout) begin
      errors++; $display("FAIL extcen_dout got=%h exp=%h", bus.ram_dout, e.dout);
    end
    checks++;
    if (bus.cpu_cen !== 1'b0) begin
      errors++; $display("FAIL extcen_cpu_cen got=%b exp=0", bus.cpu_cen);
    end
    @(negedge clk);
    cen = 1'b1;
  endtask

  function automatic logic [23:0] pick_addr();
    logic [23:0] a;
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) begin
      a = (r == 0) ? 24'h005FFE : 24'h004000 + 24'($urandom_range(0, 15) * 2);
    end else if (r < 8) begin
      case ($urandom_range(0, 4))
        0: a = 24'h200100;
        1: a = 24'h200102;
        2: a = 24'h200104;
        3: a = 24'h3FFFFE;
        default: a = 24'h200000;
      endcase
    end else begin
      case ($urandom_range(0, 4))
        0: a = 24'h003FFE;
        1: a = 24'h006000;
        2: a = 24'h1FFFFE;
        3: a = 24'h400000;
        default: a = 24'h800000;
      endcase
    end
    a[0] = 1'($urandom);
    return a;
  endfunction

  task automatic test_random();
    acc_t c;
    exp_t e;
    obs_t o;
    for (int n = 0; n < 150; n++) begin
      c.a   = pick_addr();
      c.d   = 16'($urandom);
      c.we  = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
      c.dly = $urandom_range(0, TO);
      c.val = 16'($urandom);
      model(c, e);
      drive_access(c, o);
      check_access("rnd", n, e, o);
    end
  endtask

  task automatic test_reset_in_ext();
    @(negedge clk);
    bus.ram_addr = 24'h200380; bus.ram_we = 2'b00;
    @(posedge clk); #1;
    bus.ram_addr = PARK;
    checks++;
    if (bus.ext_req !== 1'b1) begin
      errors++; $display("FAIL rstext_req1 got=%b exp=1", bus.ext_req);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (bus.ext_req !== 1'b0) begin
      errors++; $display("FAIL rstext_req0 got=%b exp=0", bus.ext_req);
    end
    checks++;
    if (bus.cpu_cen !== cen) begin
      errors++; $display("FAIL rstext_cpu_cen got=%b exp=%b", bus.cpu_cen, cen);
    end
    checks++;
    if (bus.ram_dout !== 16'h0) begin
      errors++; $display("FAIL rstext_dout got=%h exp=0000", bus.ram_dout);
    end
    bus.ext_ack = 1'b1; bus.ext_dout = 16'h1111;
    @(posedge clk); #1;
    bus.ext_ack = 1'b0;
    checks++;
    if (bus.ext_req !== 1'b0) begin
      errors++; $display("FAIL lateack_req got=%b exp=0", bus.ext_req);
    end
    checks++;
    if (bus.ram_dout !== 16'hFFFF) begin
      errors++; $display("FAIL lateack_dout got=%h exp=ffff", bus.ram_dout);
    end
    checks++;
    if (bus.bus_err !== 1'b0) begin
      errors++; $display("FAIL lateack_err got=%b exp=0", bus.bus_err);
    end
    checks++;
    if (bus.cpu_cen !== 1'b1) begin
      errors++; $display("FAIL lateack_cpu_cen got=%b exp=1", bus.cpu_cen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cen_hold();
    test_ext_cen_low();
    test_random();
    test_reset_in_ext();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt900h_bus_resp.md
Name: jt900h_bus_resp

Overview:
Memory-side responder for the CPU's 16-bit RAM bus: ram_addr, ram_din, ram_we and ram_dout. It decodes each access into one of three regions: internal block RAM (zero wait), an external word port with a req/ack handshake and timeout, or unmapped. It stalls the CPU by generating its clock enable, cpu_cen, while an external access is outstanding. A one-entry read buffer avoids repeated external fetches of the same word.

Parameters:
RAM_BASE, 24'h004000, byte base address of the internal RAM
RAM_AW, 12, internal RAM word-address width (4096 words = 8 KB)
EXT_BASE, 24'h200000, first byte address of the external region
EXT_END, 24'h3FFFFF, last byte address of the external region
TIMEOUT, 255, maximum cycles ext_req stays high without ext_ack
UNMAP_DATA, 16'hFFFF, read value for unmapped or timed-out reads

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active high
cen  in  1  system clock enable
cpu_cen  out  1  CPU clock enable: cen & ~busy
ram_addr  in  24  CPU byte address; bit 0 is ignored and word = ram_addr[23:1]
ram_din  in  16  CPU write data
ram_we  in  2  byte write enables: [0] low byte, [1] high byte; 0 = read
ram_dout  out  16  read data returned to the CPU
ext_addr  out  23  external word address
ext_din  out  16  external write data
ext_we  out  2  external byte write enables
ext_req  out  1  external request; held high until ack or timeout
ext_ack  in  1  external completion; one-cycle pulse
ext_dout  in  16  external read data, valid with ext_ack
bus_err  out  1  sticky timeout flag

Behaviour:
- Clock is clk. Reset rst is synchronous and active high.
- Reset values: ram_dout=0, busy=0, ext_req=0, ext_we=0, ext_addr=0, ext_din=0, bus_err=0, buffer invalid, state IDLE.
- An access is sampled at the end of every cycle in which cpu_cen=1.
- Decode priority: internal RAM first (RAM_BASE to RAM_BASE+2^(RAM_AW+1)-1), then external (EXT_BASE to EXT_END), otherwise unmapped.
- Internal RAM:
  - Registered read: ram_dout holds the data on the next cycle, with no stall.
  - Writes apply byte enables; ram_dout on the following cycle shows the pre-write word (read-first).
- Unmapped: reads return UNMAP_DATA on the next cycle; writes are dropped; no stall.
- External access, when the access is a write, or a read that misses the buffer:
  - At the sampling edge: busy=1, ext_req=1, and ext_addr, ext_we and ext_din are latched from the CPU; state goes to EXT.
  - cpu_cen is 0 from the next cycle. The CPU holds its address while stalled.
- EXT state:
  - The wait counter increments every clk, independent of cen.
  - When ext_ack=1: latch ext_dout into ram_dout (reads only); clear ext_req and busy; state goes to IDLE. cpu_cen rises on the following cycle. Minimum stall is 1 cycle (ack in the first EXT cycle).
  - When the counter reaches TIMEOUT without ack: abort with the same exit, but ram_dout=UNMAP_DATA and bus_err=1.
  - If ack and timeout occur in the same cycle, ack wins.
  - ext_ack while IDLE is ignored.
- Read buffer:
  - Valid and tagged with the word address after a successful external read.
  - An external read hitting the tag returns the buffered data next cycle, with no stall and no ext_req.
  - Any external write to the tagged word updates the buffered bytes per ram_we; any external write elsewhere leaves it unchanged.
  - A timeout invalidates the buffer.
- cen=0 in IDLE: no sampling and outputs hold. In EXT, the handshake continues regardless of cen.
- rst during EXT: ext_req drops on the next cycle and any later ack is ignored.
- bus_err clears only on rst.

Decomposition:
- Shared include file jt900h_bus.vh: FSM state encodings (IDLE, EXT) and region-select constants (REG_RAM, REG_EXT, REG_NONE).
- Sub-module jt900h_bus_ram: single-port RAM with byte enables and registered read, parameterised by RAM_AW.
- Decode, FSM, timeout counter and read buffer stay in the top module.

Test Plan:
- Internal write then read: write ram_addr=24'h004010, ram_we=2'b11, ram_din=16'hA55A; next access reads 24'h004010 -> ram_dout=16'hA55A one cycle later, cpu_cen never low.
- Byte write: write 16'h12 with ram_we=2'b01 over A55A -> readback 16'hA512.
- External read, ack after 3 cycles with ext_dout=16'hBEEF at 24'h200100:
  - ext_addr=23'h100080, ext_req high 3 cycles, cpu_cen low 3 cycles, then ram_dout=16'hBEEF.
  - Same read again -> no ext_req, BEEF returned with no stall.
- External write of 16'h1234 with we=2'b10 to the buffered word, ack in the first cycle -> ext_we=2'b10; a following read hits the buffer -> 16'h12EF.
- No ack with TIMEOUT=8 -> ext_req drops after 8 cycles, ram_dout=16'hFFFF, bus_err=1; the next read of the same address issues ext_req again.
- Unmapped read at 24'h800000 -> ram_dout=16'hFFFF, no stall. rst asserted in the 2nd EXT cycle -> ext_req=0 and cpu_cen=cen the next cycle, and a later ack changes nothing.
